// File: rtl/risc_pkg.sv
// Shared definitions for the fetch stage and the control unit:
// instruction width, fetch FSM states and ALU control encodings.
package risc_pkg;

    localparam int OPCODE_W = 17;

    typedef enum logic [1:0] {
        S_REQ   = 2'b00,
        S_HOLD  = 2'b01,
        S_FLUSH = 2'b10,
        S_HALT  = 2'b11
    } fetch_state_t;

    localparam logic [2:0] ALU_ADD = 3'b001;
    localparam logic [2:0] ALU_SUB = 3'b010;
    localparam logic [2:0] ALU_AND = 3'b011;
    localparam logic [2:0] ALU_OR  = 3'b100;

endpackage

// File: rtl/fetch_watchdog.sv
// Counts consecutive cycles a fetch request waits without an ack and
// flags expiry; instantiated by instr_fetch only under FETCH_TIMEOUT_EN.
module fetch_watchdog #(
    parameter int TIMEOUT_CYC = 15
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    input  logic tick,
    output logic expired
);
    localparam int CNT_W = $clog2(TIMEOUT_CYC + 1);

    logic [CNT_W-1:0] cnt_r;

    // Expiry fires on the cycle that would complete the TIMEOUT_CYC-th wait
    always_comb begin
        expired = tick && !clear && (cnt_r == CNT_W'(TIMEOUT_CYC - 1));
    end

    // Wait counter, restarted whenever a new request begins or data returns
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt_r <= '0;
        end else if (clear) begin
            cnt_r <= '0;
        end else if (tick) begin
            cnt_r <= cnt_r + CNT_W'(1);
        end else begin
            cnt_r <= cnt_r;
        end
    end

endmodule

// File: rtl/instr_fetch.sv
// Instruction fetch stage: PC, imem req/ack handshake, instruction register,
// stall and branch redirect with in-flight flush. Ack timeout under FETCH_TIMEOUT_EN.
module instr_fetch
    import risc_pkg::*;
#(
    parameter int                ADDR_W      = 8,
    parameter int                OPCODE_W    = 17,
    parameter logic [ADDR_W-1:0] PC_RESET    = '0,
    parameter int                TIMEOUT_CYC = 15
) (
    input  logic                clk,
    input  logic                rst_n,
    output logic                imem_req,
    output logic [ADDR_W-1:0]   imem_addr,
    input  logic                imem_ack,
    input  logic [OPCODE_W-1:0] imem_rdata,
    input  logic                stall,
    input  logic                branch_valid,
    input  logic [ADDR_W-1:0]   branch_target,
    output logic [OPCODE_W-1:0] opcode,
    output logic                opcode_valid,
    output logic [ADDR_W-1:0]   pc_out,
    output logic                fetch_err
);
    fetch_state_t          state_r, state_s;
    logic [ADDR_W-1:0]     pc_r, pc_s;
    logic [ADDR_W-1:0]     addr_r;
    logic [ADDR_W-1:0]     pc_out_r;
    logic [OPCODE_W-1:0]   opcode_r;
    logic                  req_r;
    logic                  valid_r, valid_s;
    logic                  err_r;
    logic                  capture_s;
    logic                  ack_s;
    logic                  timeout_s;

    assign ack_s = req_r && imem_ack;

`ifdef FETCH_TIMEOUT_EN
    logic wd_clear_s;
    logic wd_tick_s;

    // A wait restarts when no request is out, data returns, or a branch opens a flush
    always_comb begin
        wd_clear_s = !req_r || ack_s || ((state_r == S_REQ) && branch_valid);
        wd_tick_s  = req_r && !ack_s;
    end

    fetch_watchdog #(
        .TIMEOUT_CYC (TIMEOUT_CYC)
    ) u_watchdog (
        .clk     (clk),
        .rst_n   (rst_n),
        .clear   (wd_clear_s),
        .tick    (wd_tick_s),
        .expired (timeout_s)
    );
`else
    assign timeout_s = 1'b0;
`endif

    // Next-state, next-PC and capture decisions
    always_comb begin
        state_s   = state_r;
        pc_s      = pc_r;
        valid_s   = valid_r;
        capture_s = 1'b0;
        case (state_r)
            S_REQ: begin
                if (timeout_s) begin
                    state_s = S_HALT;
                end else if (branch_valid) begin
                    pc_s    = branch_target;
                    valid_s = 1'b0;
                    // Only a request still awaiting its ack needs flushing
                    state_s = (ack_s || !req_r) ? S_REQ : S_FLUSH;
                end else if (ack_s) begin
                    capture_s = 1'b1;
                    pc_s      = pc_r + ADDR_W'(1);
                    valid_s   = 1'b1;
                    state_s   = S_HOLD;
                end else begin
                    state_s = S_REQ;
                end
            end
            S_HOLD: begin
                if (branch_valid) begin
                    pc_s    = branch_target;
                    valid_s = 1'b0;
                    state_s = S_REQ;
                end else if (!stall) begin
                    valid_s = 1'b0;
                    state_s = S_REQ;
                end else begin
                    state_s = S_HOLD;
                end
            end
            S_FLUSH: begin
                if (branch_valid) begin
                    pc_s = branch_target;
                end else begin
                    pc_s = pc_r;
                end
                if (timeout_s) begin
                    state_s = S_HALT;
                end else if (ack_s) begin
                    state_s = S_REQ;
                end else begin
                    state_s = S_FLUSH;
                end
            end
            S_HALT: begin
                valid_s = 1'b0;
                state_s = S_HALT;
            end
            default: begin
                valid_s = 1'b0;
                state_s = S_REQ;
            end
        endcase
    end

    // State, PC, request and instruction-register updates
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r  <= S_REQ;
            pc_r     <= PC_RESET;
            req_r    <= 1'b0;
            addr_r   <= PC_RESET;
            opcode_r <= '0;
            valid_r  <= 1'b0;
            pc_out_r <= '0;
            err_r    <= 1'b0;
        end else begin
            state_r <= state_s;
            pc_r    <= pc_s;
            valid_r <= valid_s;
            req_r   <= (state_s == S_REQ) || (state_s == S_FLUSH);
            err_r   <= err_r || timeout_s;
            if (state_s == S_REQ) begin
                addr_r <= pc_s;
            end else begin
                addr_r <= addr_r;
            end
            if (capture_s) begin
                opcode_r <= imem_rdata;
                pc_out_r <= pc_r;
            end else begin
                opcode_r <= opcode_r;
                pc_out_r <= pc_out_r;
            end
        end
    end

    assign imem_req     = req_r;
    assign imem_addr    = addr_r;
    assign opcode       = opcode_r;
    assign opcode_valid = valid_r;
    assign pc_out       = pc_out_r;
    assign fetch_err    = err_r;

endmodule
